// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered Hack-style ALU with multi-cycle shift-add multiply
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg_q;

    logic [WIDTH-1:0]   xz, yz, xp, yp;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_r, alu_res;
    logic               alu_cy;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mul_res;

    // Operand preprocessing and the single-cycle ALU result
    always_comb begin
        xz      = zx ? '0 : x;
        xp      = nx ? ~xz : xz;
        yz      = zy ? '0 : y;
        yp      = ny ? ~yz : yz;
        sum     = {1'b0, xp} + {1'b0, yp};
        alu_r   = f ? sum[WIDTH-1:0] : (xp & yp);
        alu_res = no ? ~alu_r : alu_r;
        // carry reports the add itself, so it is deliberately not inverted by no
        alu_cy  = f ? sum[WIDTH] : 1'b0;
    end

    // Next accumulator value for the current multiplier bit, and the final low half
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
        mul_res = neg_q ? ~acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    end

    // Control FSM with registered result, flags and handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            out    <= '0;
            zr     <= 1'b1;
            ng     <= 1'b0;
            cy     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!mul) begin
                            out  <= alu_res;
                            zr   <= (alu_res == '0);
                            ng   <= alu_res[WIDTH-1];
                            cy   <= alu_cy;
                            done <= 1'b1;
                        end else begin
                            // operands are captured here so later input changes cannot disturb the run
                            mcand  <= {{WIDTH{1'b0}}, xp};
                            mplier <= yp;
                            acc    <= '0;
                            cnt    <= '0;
                            neg_q  <= no;
                            busy   <= 1'b1;
                            state  <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out   <= mul_res;
                        zr    <= (mul_res == '0);
                        ng    <= mul_res[WIDTH-1];
                        cy    <= |acc_nxt[2*WIDTH-1:WIDTH];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH 16 and 8
module tb_alu_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start8 = 1'b0;
    logic [15:0] x = '0, y = '0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0, mul = 0;
    logic [15:0] out;
    logic [7:0]  out8;
    logic        zr, ng, cy, busy, done;
    logic        zr8, ng8, cy8, busy8, done8;

    int passed = 0;
    int total  = 0;
    int first, ndone, nbusy;

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(16)) u16 (
        .clock(clock), .reset(reset), .start(start), .x(x), .y(y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
        .out(out), .zr(zr), .ng(ng), .cy(cy), .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .clock(clock), .reset(reset), .start(start8), .x(x8), .y(y8),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
        .out(out8), .zr(zr8), .ng(ng8), .cy(cy8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // called right after the start edge has been sampled; watches ncyc further edges
    task automatic watch(input bit w8, input int ncyc, input bit repulse,
                         output int first_done, output int n_done, output int n_busy);
        first_done = -1;
        n_done = 0;
        n_busy = 0;
        for (int j = 0; j <= ncyc; j++) begin
            if (j > 0) step();
            if ((w8 ? busy8 : busy) === 1'b1) n_busy++;
            if ((w8 ? done8 : done) === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = j;
            end
            if (repulse && j == 4) begin
                start = 1'b1; x = 16'd1; y = 16'd1; mul = 1'b0;
            end
            if (repulse && j == 5) start = 1'b0;
        end
    endtask

    initial begin
        // reset and idle
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        check("rst_out", out, 0);
        check("rst_zr", zr, 1);
        check("rst_ng", ng, 0);
        check("rst_cy", cy, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // 0x7FFF + 1
        x = 16'h7FFF; y = 16'h0001; f = 1; start = 1;
        step();
        start = 0;
        check("add_out", out, 16'h8000);
        check("add_ng", ng, 1);
        check("add_zr", zr, 0);
        check("add_cy", cy, 0);
        check("add_done", done, 1);
        step();
        check("add_done_drop", done, 0);

        // 0xFFFF + 1 wraps, then back-to-back x-1 on x=5
        x = 16'hFFFF; y = 16'h0001; f = 1; start = 1;
        step();
        check("wrap_out", out, 0);
        check("wrap_zr", zr, 1);
        check("wrap_cy", cy, 1);
        check("wrap_done", done, 1);
        x = 16'd5; zy = 1; ny = 1; f = 1;
        step();
        start = 0;
        check("xm1_out", out, 16'd4);
        check("xm1_done", done, 1);
        check("xm1_cy", cy, 1);
        step();
        check("xm1_done_drop", done, 0);

        // and with output inversion: ~(5 & 3) = 0xFFFE
        zy = 0; ny = 0; f = 0; no = 1; x = 16'd5; y = 16'd3; start = 1;
        step();
        start = 0;
        check("nand_out", out, 16'hFFFE);
        check("nand_ng", ng, 1);
        check("nand_cy", cy, 0);
        no = 0;

        // multiply 3 x 5
        x = 16'd3; y = 16'd5; mul = 1; start = 1;
        step();
        start = 0;
        watch(1'b0, 20, 1'b0, first, ndone, nbusy);
        check("m35_latency", first, 16);
        check("m35_ndone", ndone, 1);
        check("m35_busy", nbusy, 16);
        check("m35_out", out, 16'd15);
        check("m35_cy", cy, 0);
        check("m35_zr", zr, 0);

        // 0x100 x 0x100 = 0x10000
        x = 16'h0100; y = 16'h0100; mul = 1; start = 1;
        step();
        start = 0;
        watch(1'b0, 20, 1'b0, first, ndone, nbusy);
        check("m256_latency", first, 16);
        check("m256_out", out, 0);
        check("m256_zr", zr, 1);
        check("m256_cy", cy, 1);

        // 7 x 9 with start re-pulsed and operands changed while busy
        x = 16'd7; y = 16'd9; mul = 1; start = 1;
        step();
        start = 0;
        watch(1'b0, 24, 1'b1, first, ndone, nbusy);
        check("m79_ndone", ndone, 1);
        check("m79_latency", first, 16);
        check("m79_out", out, 16'd63);

        // reset in the middle of a multiply
        x = 16'd3; y = 16'd5; mul = 1; start = 1;
        step();
        start = 0;
        repeat (5) step();
        check("abort_busy_before", busy, 1);
        reset = 1;
        #1;
        check("abort_out", out, 0);
        check("abort_zr", zr, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        step();
        reset = 0;
        mul = 0;
        watch(1'b0, 20, 1'b0, first, ndone, nbusy);
        check("abort_no_done", ndone, 0);
        x = 16'd2; y = 16'd3; f = 1; start = 1;
        step();
        start = 0;
        check("post_rst_out", out, 16'd5);
        check("post_rst_done", done, 1);

        // 8-bit instance: 0xFF x 0xFF = 0xFE01
        x8 = 8'hFF; y8 = 8'hFF; mul = 1; f = 0; start8 = 1;
        step();
        start8 = 0;
        watch(1'b1, 12, 1'b0, first, ndone, nbusy);
        check("w8_latency", first, 8);
        check("w8_ndone", ndone, 1);
        check("w8_out", out8, 8'h01);
        check("w8_cy", cy8, 1);
        check("w8_zr", zr8, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
